conv_sched: RTL and testbench
=============================

# conv_sched

Sequencing controller for the PHY parallel-to-serial converter. Accepts 32-bit words from an upstream requester over a valid/ready handshake. Splits each word into 32-, 16- or 8-bit chunks according to the `PCLK` width code. Issues each chunk to the serializer with a one-cycle load strobe, then counts one cycle per serialized bit before issuing the next chunk, so back-to-back words stream with no idle gap.

## Interface
Parameters:
- `CNT_W`, 16, width of the accepted-word counter `WORD_CNT`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET_L` in 1: asynchronous, active-low reset.
- `ENB` in 1: global enable, shared with the serializer. Low freezes all state.
- `PCLK` in 2: chunk width code, 00=32, 01=16, 10=8, 11=reserved (treated as 8). Sampled only at word acceptance.
- `IN_VALID` in 1: upstream word valid.
- `IN` in 32: upstream word.
- `IN_READY` out 1: controller can accept a word this cycle.
- `LD` out 1: one-cycle load strobe to the serializer.
- `CHUNK` out 32: current chunk, right-aligned, zero-extended. Held between strobes.
- `BUSY` out 1: high while a word is in flight.
- `WORD_DONE` out 1: one-cycle pulse after the last bit period of a word.
- `MODE_ERR` out 1: one-cycle pulse when a word is accepted with `PCLK`=11.
- `WORD_CNT` out `CNT_W`: count of completed words, wraps modulo 2^`CNT_W`.

## Operation
Registered state:
- `st` ∈ {IDLE, SEND}
- latched word
- width W ∈ {32,16,8} and chunk count N = 32/W
- chunk index `cidx` (0..N-1)
- bit counter `bcnt` (0..W-1)

Reset (`RESET_L`=0, asynchronous): `st`=IDLE and all state cleared. `LD`, `CHUNK`, `BUSY`, `WORD_DONE`, `MODE_ERR`, `WORD_CNT` all read 0. `IN_READY` is 0 while reset is asserted.

`IN_READY` (combinational) = `ENB` && (`st`==IDLE || (`st`==SEND && `cidx`==N-1 && `bcnt`==W-1)).

`BUSY` = (`st`==SEND).

Per rising edge with `ENB`=1:
- `LD`, `WORD_DONE` and `MODE_ERR` default to 0.
- SEND with `bcnt`==W-1 and `cidx`==N-1 (word finishing): `WORD_DONE`<=1, `WORD_CNT`<=`WORD_CNT`+1, `st`<=IDLE, unless a word is also accepted on this edge (next rule).
- Accept (`IN_VALID` && `IN_READY`):
  - latch `IN`; latch W from `PCLK`; `MODE_ERR`<=(`PCLK`==11)
  - `cidx`<=0, `bcnt`<=0, `st`<=SEND, `LD`<=1
  - `CHUNK`<=`IN`[31:32-W], zero-extended
  - a simultaneous finish still pulses `WORD_DONE` and increments `WORD_CNT`
- SEND with `bcnt`==W-1 and `cidx`<N-1: `cidx`++, `bcnt`<=0, `LD`<=1, `CHUNK`<=next chunk (high chunk first, i.e. word[31-W·c : 32-W·(c+1)]).
- SEND otherwise: `bcnt`++.
- IDLE with no accept: hold.

With `ENB`=0:
- all state, `CHUNK` and `WORD_CNT` hold
- `LD`, `WORD_DONE`, `MODE_ERR` are 0
- no acceptance (`IN_READY`=0)
- when `ENB` returns, counting resumes at the frozen `bcnt`

`PCLK` changes while `st`==SEND have no effect until the next acceptance.

## Timing
- Accept on edge k: `LD`=1 and chunk 0 on `CHUNK` in the cycle after edge k. The cycle of edge k counts as bit 0.
- Strobe spacing is exactly W enabled cycles. Strobes fall at edges k, k+W, …, k+(N-1)W.
- Word occupies 32 enabled cycles regardless of mode. `WORD_DONE` is asserted after edge k+32.
- Back-to-back: next word is accepted on edge k+32; its `LD` coincides with the previous `WORD_DONE`, with zero gap.
- `IN_VALID` may drop without acceptance; no state change results.
- Reset mid-word aborts the word: no `WORD_DONE`, counter cleared.

## Test plan
- Reset release, `ENB`=1, `PCLK`=00, `IN`=0x0F00FF55 valid one cycle -> single `LD` with `CHUNK`=0x0F00FF55; `BUSY` for 32 cycles; `WORD_DONE` 32 cycles after accept; `WORD_CNT`=1.
- `PCLK`=10, `IN`=0x0F00FF55 -> `LD` every 8 cycles with `CHUNK`=0x0F, 0x00, 0xFF, 0x55; then `WORD_DONE`.
- `PCLK`=01, `IN_VALID` held with 0xAA0F00FF then 0x0FF0FF00 -> `CHUNK`=0xAA0F, 0x00FF, 0x0FF0, 0xFF00 at exact 16-cycle spacing; first `WORD_DONE` coincides with the third `LD`; `WORD_CNT`=2.
- `PCLK`=10, `ENB` low for 5 cycles during chunk 1 -> that strobe interval stretches to 13 cycles; no `LD` or `IN_READY` while low; chunk order unchanged.
- `PCLK`=11, `IN`=0xAAFF00AA -> `MODE_ERR` one-cycle pulse at first `LD`; chunks 0xAA, 0xFF, 0x00, 0xAA at 8-cycle spacing.
- `RESET_L` pulsed low mid-word (`PCLK`=00, cycle 10 of 32) -> all outputs 0 immediately; no `WORD_DONE`; `IN_READY`=1 in the first enabled cycle after release.

Source files
------------

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - serializer sequencing controller: splits 32-bit words into 32/16/8-bit chunks
// Each chunk gets a one-cycle LD strobe followed by one cycle per serialized bit.
module conv_sched #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [1:0]       PCLK,
  input  logic             IN_VALID,
  input  logic [31:0]      IN,
  output logic             IN_READY,
  output logic             LD,
  output logic [31:0]      CHUNK,
  output logic             BUSY,
  output logic             WORD_DONE,
  output logic             MODE_ERR,
  output logic [CNT_W-1:0] WORD_CNT
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Width code: 0 = 32-bit, 1 = 16-bit, 2 = 8-bit (reserved code 3 folded into 2).
  logic [0:0]       st_q, st_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       cidx_q, cidx_d;
  logic [4:0]       bcnt_q, bcnt_d;
  logic [31:0]      chunk_q, chunk_d;
  logic             ld_q, ld_d;
  logic             done_q, done_d;
  logic             merr_q, merr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] wm1;
  logic [1:0] nm1;
  logic       last_bit;
  logic       last_chunk;
  logic       finishing;
  logic       accept;
  logic [1:0] in_mode;

  function automatic logic [31:0] chunk_sel(input logic [31:0] w, input logic [1:0] m,
                                            input logic [1:0] c);
    logic [31:0] r;
    case (m)
      2'd0:    r = w;
      2'd1:    r = c[0] ? {16'h0, w[15:0]} : {16'h0, w[31:16]};
      default: begin
        case (c)
          2'd0:    r = {24'h0, w[31:24]};
          2'd1:    r = {24'h0, w[23:16]};
          2'd2:    r = {24'h0, w[15:8]};
          default: r = {24'h0, w[7:0]};
        endcase
      end
    endcase
    return r;
  endfunction

  always_comb begin
    case (mode_q)
      2'd0:    begin wm1 = 5'd31; nm1 = 2'd0; end
      2'd1:    begin wm1 = 5'd15; nm1 = 2'd1; end
      default: begin wm1 = 5'd7;  nm1 = 2'd3; end
    endcase
  end

  assign last_bit   = (bcnt_q == wm1);
  assign last_chunk = (cidx_q == nm1);
  assign finishing  = (st_q == ST_SEND) && last_bit && last_chunk;
  assign IN_READY   = RESET_L && ENB && ((st_q == ST_IDLE) || finishing);
  assign accept     = IN_VALID && IN_READY;
  assign in_mode    = (PCLK == 2'b11) ? 2'd2 : PCLK;

  always_comb begin
    st_d    = st_q;
    word_d  = word_q;
    mode_d  = mode_q;
    cidx_d  = cidx_q;
    bcnt_d  = bcnt_q;
    chunk_d = chunk_q;
    cnt_d   = cnt_q;
    ld_d    = 1'b0;
    done_d  = 1'b0;
    merr_d  = 1'b0;
    if (ENB) begin
      if (st_q == ST_SEND) begin
        if (last_bit) begin
          if (last_chunk) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            st_d   = ST_IDLE;
          end else begin
            cidx_d  = cidx_q + 2'd1;
            bcnt_d  = 5'd0;
            ld_d    = 1'b1;
            chunk_d = chunk_sel(word_q, mode_q, cidx_q + 2'd1);
          end
        end else begin
          bcnt_d = bcnt_q + 5'd1;
        end
      end
      // An accept on the finishing edge overrides the return to idle.
      if (accept) begin
        word_d  = IN;
        mode_d  = in_mode;
        merr_d  = (PCLK == 2'b11);
        cidx_d  = 2'd0;
        bcnt_d  = 5'd0;
        st_d    = ST_SEND;
        ld_d    = 1'b1;
        chunk_d = chunk_sel(IN, in_mode, 2'd0);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      st_q    <= ST_IDLE;
      word_q  <= 32'h0;
      mode_q  <= 2'd0;
      cidx_q  <= 2'd0;
      bcnt_q  <= 5'd0;
      chunk_q <= 32'h0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      merr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      cidx_q  <= cidx_d;
      bcnt_q  <= bcnt_d;
      chunk_q <= chunk_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      merr_q  <= merr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LD        = ld_q;
  assign CHUNK     = chunk_q;
  assign BUSY      = (st_q == ST_SEND);
  assign WORD_DONE = done_q;
  assign MODE_ERR  = merr_q;
  assign WORD_CNT  = cnt_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - directed self-checking bench for conv_sched
module tb_conv_sched;

  logic        CLK;
  logic        RESET_L;
  logic        ENB;
  logic [1:0]  PCLK;
  logic        IN_VALID;
  logic [31:0] IN;
  logic        IN_READY;
  logic        LD;
  logic [31:0] CHUNK;
  logic        BUSY;
  logic        WORD_DONE;
  logic        MODE_ERR;
  logic [15:0] WORD_CNT;

  int errors = 0;
  int checks = 0;

  conv_sched #(.CNT_W(16)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .PCLK(PCLK),
    .IN_VALID(IN_VALID), .IN(IN), .IN_READY(IN_READY), .LD(LD),
    .CHUNK(CHUNK), .BUSY(BUSY), .WORD_DONE(WORD_DONE),
    .MODE_ERR(MODE_ERR), .WORD_CNT(WORD_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word accepted from idle, every cycle of its 32-cycle life checked.
  task automatic check_word(input logic [1:0] pc, input logic [31:0] w, input int width,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3,
                            input logic merr_exp, input logic [15:0] cnt_exp);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    PCLK = pc; IN = w; IN_VALID = 1'b1;
    #1;
    chk("ready before accept", IN_READY, 1);
    cyc();
    IN_VALID = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j % width == 0) begin
        chk($sformatf("ld j=%0d", j), LD, 1);
        chk($sformatf("chunk j=%0d", j), CHUNK, e[j / width]);
      end else begin
        chk($sformatf("no ld j=%0d", j), LD, 0);
      end
      chk($sformatf("busy j=%0d", j), BUSY, 1);
      chk($sformatf("ready j=%0d", j), IN_READY, (j == 31) ? 1 : 0);
      if (j == 0) chk("mode_err at first ld", MODE_ERR, merr_exp);
      if (j == 1) chk("mode_err one cycle", MODE_ERR, 0);
      if (j < 31) cyc();
    end
    cyc();
    chk("word_done", WORD_DONE, 1);
    chk("idle after word", BUSY, 0);
    chk("word_cnt", WORD_CNT, cnt_exp);
    chk("no ld at done", LD, 0);
    cyc();
    chk("word_done one cycle", WORD_DONE, 0);
  endtask

  initial begin
    RESET_L = 1'b0; ENB = 1'b1; PCLK = 2'b00; IN_VALID = 1'b0; IN = 32'h0;
    cyc();
    chk("rst ld", LD, 0);
    chk("rst chunk", CHUNK, 0);
    chk("rst busy", BUSY, 0);
    chk("rst word_done", WORD_DONE, 0);
    chk("rst mode_err", MODE_ERR, 0);
    chk("rst word_cnt", WORD_CNT, 0);
    chk("rst in_ready", IN_READY, 0);
    RESET_L = 1'b1;
    #1;
    chk("ready after release", IN_READY, 1);

    // 32-bit mode: single strobe carrying the whole word
    check_word(2'b00, 32'h0F00FF55, 32, 32'h0F00FF55, 0, 0, 0, 1'b0, 16'd1);

    // 8-bit mode
    check_word(2'b10, 32'h0F00FF55, 8, 32'h0F, 32'h00, 32'hFF, 32'h55, 1'b0, 16'd2);

    // 16-bit mode, back-to-back with IN_VALID held
    PCLK = 2'b01; IN = 32'hAA0F00FF; IN_VALID = 1'b1;
    cyc();
    chk("b2b ld0", LD, 1);
    chk("b2b chunk0", CHUNK, 32'hAA0F);
    IN = 32'h0FF0FF00;
    for (int j = 1; j < 32; j++) begin
      cyc();
      chk($sformatf("b2b ld j=%0d", j), LD, (j == 16) ? 1 : 0);
      if (j == 16) chk("b2b chunk1", CHUNK, 32'h00FF);
    end
    chk("b2b ready at finish", IN_READY, 1);
    cyc();
    chk("b2b ld2", LD, 1);
    chk("b2b chunk2", CHUNK, 32'h0FF0);
    chk("b2b done coincides", WORD_DONE, 1);
    chk("b2b cnt3", WORD_CNT, 16'd3);
    chk("b2b busy kept", BUSY, 1);
    IN_VALID = 1'b0;
    for (int j = 33; j < 64; j++) begin
      cyc();
      chk($sformatf("b2b ld j=%0d", j), LD, (j == 48) ? 1 : 0);
      if (j == 48) chk("b2b chunk3", CHUNK, 32'hFF00);
      if (j == 33) chk("b2b done cleared", WORD_DONE, 0);
    end
    cyc();
    chk("b2b done2", WORD_DONE, 1);
    chk("b2b cnt4", WORD_CNT, 16'd4);
    chk("b2b idle", BUSY, 0);
    cyc();

    // Valid without readiness (ENB low) and dropped valid cause no state change
    ENB = 1'b0; IN_VALID = 1'b1; IN = 32'hDEADBEEF;
    #1;
    chk("no ready when disabled", IN_READY, 0);
    cyc();
    chk("no accept disabled busy", BUSY, 0);
    chk("no accept disabled ld", LD, 0);
    IN_VALID = 1'b0; ENB = 1'b1;
    cyc();
    chk("valid dropped busy", BUSY, 0);
    chk("valid dropped cnt", WORD_CNT, 16'd4);

    // 8-bit mode with ENB low for 5 cycles during chunk 1
    PCLK = 2'b10; IN = 32'h12345678; IN_VALID = 1'b1;
    cyc();
    IN_VALID = 1'b0;
    chk("enb ld0", LD, 1);
    chk("enb chunk0", CHUNK, 32'h12);
    for (int j = 1; j <= 10; j++) begin
      cyc();
      chk($sformatf("enb ld j=%0d", j), LD, (j == 8) ? 1 : 0);
      if (j == 8) chk("enb chunk1", CHUNK, 32'h34);
    end
    ENB = 1'b0;
    #1;
    chk("enb low ready", IN_READY, 0);
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk($sformatf("frozen ld %0d", j), LD, 0);
      chk($sformatf("frozen ready %0d", j), IN_READY, 0);
      chk($sformatf("frozen busy %0d", j), BUSY, 1);
      chk($sformatf("frozen chunk %0d", j), CHUNK, 32'h34);
    end
    ENB = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk($sformatf("resume no ld %0d", j), LD, 0);
    end
    cyc();
    chk("stretched ld2", LD, 1);
    chk("stretched chunk2", CHUNK, 32'h56);
    for (int j = 0; j < 7; j++) begin
      cyc();
      chk($sformatf("gap3 ld %0d", j), LD, 0);
    end
    cyc();
    chk("enb ld3", LD, 1);
    chk("enb chunk3", CHUNK, 32'h78);
    for (int j = 0; j < 7; j++) cyc();
    chk("enb ready at finish", IN_READY, 1);
    cyc();
    chk("enb done", WORD_DONE, 1);
    chk("enb cnt5", WORD_CNT, 16'd5);
    cyc();

    // Reserved width code behaves as 8-bit and flags MODE_ERR
    check_word(2'b11, 32'hAAFF00AA, 8, 32'hAA, 32'hFF, 32'h00, 32'hAA, 1'b1, 16'd6);

    // Reset in the middle of a 32-bit word
    PCLK = 2'b00; IN = 32'h13579BDF; IN_VALID = 1'b1;
    cyc();
    IN_VALID = 1'b0;
    for (int j = 0; j < 10; j++) cyc();
    chk("pre-reset busy", BUSY, 1);
    RESET_L = 1'b0;
    #1;
    chk("mid rst ld", LD, 0);
    chk("mid rst chunk", CHUNK, 0);
    chk("mid rst busy", BUSY, 0);
    chk("mid rst done", WORD_DONE, 0);
    chk("mid rst mode_err", MODE_ERR, 0);
    chk("mid rst cnt", WORD_CNT, 0);
    chk("mid rst ready", IN_READY, 0);
    cyc();
    cyc();
    RESET_L = 1'b1;
    #1;
    chk("ready after mid rst", IN_READY, 1);
    for (int j = 0; j < 30; j++) begin
      cyc();
      chk($sformatf("aborted no done %0d", j), WORD_DONE, 0);
    end
    chk("aborted cnt", WORD_CNT, 0);
    chk("aborted idle", BUSY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
